// File: rtl/canny_pkg.sv
// Shared definitions for the Canny edge pipeline: frame-controller state encoding
// and default raster dimensions.
package canny_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

endpackage

// File: rtl/raster_cnt.sv
// Column/row raster position counter with optional clear, advance enable and
// last-column/last-row flags. Clear and enable together load position 1.
module raster_cnt import canny_pkg::*; #(
  parameter int W = DEF_IMG_W,
  parameter int H = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(W)-1:0] o_col,
  output logic [$clog2(H)-1:0] o_row,
  output logic                 o_col_last,
  output logic                 o_row_last
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0] r_col, w_col_base, w_col_nxt;
  logic [RW-1:0] r_row, w_row_base, w_row_nxt;

  // Clear is applied first so a clear+advance lands on the second raster position.
  always_comb begin
    w_col_base = i_clr ? '0 : r_col;
    w_row_base = i_clr ? '0 : r_row;
    w_col_nxt  = w_col_base;
    w_row_nxt  = w_row_base;
    if (i_en) begin
      if (w_col_base == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (w_row_base == ROW_LAST) ? '0 : w_row_base + RW'(1);
      end else begin
        w_col_nxt = w_col_base + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_col_last = (r_col == COL_LAST);
  assign o_row_last = (r_row == ROW_LAST);

endmodule

// File: rtl/nms_frame_ctrl.sv
// Raster-frame sequencer for the 8-direction NMS stage: qualifies 3x3 window
// centres, flags border centres, drains the tail and emits latency-aligned sync.
module nms_frame_ctrl import canny_pkg::*; #(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int NMS_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_valid,
  input  logic pix_sof,
  output logic pix_ready,
  output logic win_valid,
  output logic win_border,
  output logic out_sof,
  output logic out_eol,
  output logic out_eof,
  output logic busy,
  output logic err_sof,
  output logic err_drop
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);

  state_e        r_state, w_state_nxt;
  logic [FW-1:0] r_flush;
  logic          w_in_clr, w_in_en, w_out_clr;
  logic [CW-1:0] w_in_col, w_out_col;
  logic [RW-1:0] w_in_row, w_out_row;
  logic          w_in_col_last, w_in_row_last, w_out_col_last, w_out_row_last;
  logic [2:0]    w_sync_in;
  logic [NMS_LAT-1:0][2:0] r_sync;

  raster_cnt #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
    .clk(clk), .rst(rst), .i_clr(w_in_clr), .i_en(w_in_en),
    .o_col(w_in_col), .o_row(w_in_row),
    .o_col_last(w_in_col_last), .o_row_last(w_in_row_last)
  );

  raster_cnt #(.W(IMG_W), .H(IMG_H)) u_out_cnt (
    .clk(clk), .rst(rst), .i_clr(w_out_clr), .i_en(win_valid),
    .o_col(w_out_col), .o_row(w_out_row),
    .o_col_last(w_out_col_last), .o_row_last(w_out_row_last)
  );

  // The first centre (o=0) becomes valid once input index IMG_W+1 (row 1, col 1) arrives.
  always_comb begin
    w_state_nxt = r_state;
    pix_ready   = 1'b1;
    win_valid   = 1'b0;
    w_in_clr    = 1'b0;
    w_in_en     = 1'b0;
    w_out_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pix_valid && pix_sof) begin
          w_state_nxt = S_PRIME;
          w_in_clr    = 1'b1;
          w_in_en     = 1'b1;
          w_out_clr   = 1'b1;
        end
      end
      S_PRIME, S_RUN: begin
        if (pix_valid && pix_sof) begin
          w_state_nxt = S_PRIME;
          w_in_clr    = 1'b1;
          w_in_en     = 1'b1;
          w_out_clr   = 1'b1;
        end else if (pix_valid) begin
          w_in_en = 1'b1;
          if (r_state == S_RUN) begin
            win_valid = 1'b1;
            if (w_in_row_last && w_in_col_last) w_state_nxt = S_FLUSH;
          end else if (w_in_row == RW'(1) && w_in_col == CW'(1)) begin
            win_valid   = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        pix_ready = 1'b0;
        win_valid = 1'b1;
        if (r_flush == FW'(IMG_W)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_FLUSH) r_flush <= '0;
    else                           r_flush <= r_flush + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sof  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      if (pix_valid && pix_sof && (r_state == S_PRIME || r_state == S_RUN)) err_sof <= 1'b1;
      if (pix_valid && !pix_ready) err_drop <= 1'b1;
    end
  end

  assign win_border = (w_out_row == '0) || w_out_row_last || (w_out_col == '0) || w_out_col_last;
  assign busy       = (r_state != S_IDLE);

  // Sync flags are taken at the window cycle and delayed to match the NMS result.
  assign w_sync_in[2] = win_valid && (w_out_row == '0) && (w_out_col == '0);
  assign w_sync_in[1] = win_valid && w_out_col_last;
  assign w_sync_in[0] = win_valid && w_out_col_last && w_out_row_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      for (int k = NMS_LAT - 1; k > 0; k--) r_sync[k] <= r_sync[k-1];
      r_sync[0] <= w_sync_in;
    end
  end

  assign out_sof = r_sync[NMS_LAT-1][2];
  assign out_eol = r_sync[NMS_LAT-1][1];
  assign out_eof = r_sync[NMS_LAT-1][0];

endmodule

// File: tb/tb_nms_frame_ctrl.sv
// Self-checking bench for nms_frame_ctrl: index-based reference model compared
// every cycle, plus hand-computed per-frame totals and the border map.
module tb_nms_frame_ctrl;

  localparam int W = 5;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst, pix_valid, pix_sof;
  logic pix_ready, win_valid, win_border, out_sof, out_eol, out_eof, busy, err_sof, err_drop;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-relative pixel index, remaining drain cycles, sticky flags.
  bit mActive, mErrSof, mErrDrop, mSof, mEol, mEof;
  int mNext, mFlush;

  // Observed DUT activity, only ever incremented by the compare process.
  int obsWv = 0, obsEof = 0, obsSof = 0, obsEol = 0, obsReadyLowWv = 0;
  logic borderLog [0:8191];

  nms_frame_ctrl #(.IMG_W(W), .IMG_H(H), .NMS_LAT(1)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .win_valid(win_valid), .win_border(win_border),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
    .err_sof(err_sof), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after posedge, so at negedge they are the values the next edge samples.
  always @(negedge clk) begin
    bit eWv, eBorder;
    int eO;
    if (rst) begin
      mActive = 0; mNext = 0; mFlush = 0; mErrSof = 0; mErrDrop = 0;
      mSof = 0; mEol = 0; mEof = 0;
    end else begin
      eWv = 0;
      eO  = 0;
      if (mFlush > 0) begin
        eWv = 1;
        eO  = N - mFlush;
      end else if (pix_valid && !pix_sof && mActive && mNext >= W + 1) begin
        eWv = 1;
        eO  = mNext - (W + 1);
      end
      eBorder = (eO / W == 0) || (eO / W == H - 1) || (eO % W == 0) || (eO % W == W - 1);

      checkOutput("pix_ready", int'(pix_ready), int'(mFlush == 0));
      checkOutput("busy", int'(busy), int'(mActive || mFlush > 0));
      checkOutput("win_valid", int'(win_valid), int'(eWv));
      if (eWv) checkOutput("win_border", int'(win_border), int'(eBorder));
      checkOutput("out_sof", int'(out_sof), int'(mSof));
      checkOutput("out_eol", int'(out_eol), int'(mEol));
      checkOutput("out_eof", int'(out_eof), int'(mEof));
      checkOutput("err_sof", int'(err_sof), int'(mErrSof));
      checkOutput("err_drop", int'(err_drop), int'(mErrDrop));

      if (win_valid) begin
        borderLog[obsWv % 8192] = win_border;
        obsWv++;
        if (!pix_ready) obsReadyLowWv++;
      end
      if (out_sof) obsSof++;
      if (out_eol) obsEol++;
      if (out_eof) obsEof++;

      if (mFlush > 0) begin
        mFlush--;
        if (pix_valid) mErrDrop = 1;
      end else if (pix_valid && pix_sof) begin
        if (mActive) mErrSof = 1;
        mActive = 1;
        mNext   = 1;
      end else if (pix_valid && mActive) begin
        if (mNext == N - 1) begin
          mActive = 0;
          mNext   = 0;
          mFlush  = W + 1;
        end else begin
          mNext++;
        end
      end
      mSof = eWv && (eO == 0);
      mEol = eWv && (eO % W == W - 1);
      mEof = eWv && (eO == N - 1);
    end
  end

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendPixel(input logic sof);
    pix_valid = 1'b1;
    pix_sof   = sof;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // gap < 0 picks a random 0..3 cycle gap after each pixel.
  task automatic applyStimulus(input int nPix, input int gap, input int sofAt, input int tail);
    for (int k = 0; k < nPix; k++) begin
      sendPixel(k == 0 || k == sofAt);
      idleCycles(gap < 0 ? int'($urandom_range(0, 3)) : gap);
    end
    idleCycles(tail);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int baseWv, baseEof, baseSof, baseEol, baseLow;

  task automatic snapshot();
    baseWv  = obsWv;
    baseEof = obsEof;
    baseSof = obsSof;
    baseEol = obsEol;
    baseLow = obsReadyLowWv;
  endtask

  logic [N-1:0] borderMap;

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    borderMap = 20'b1111_1100_0110_0011_1111;
    idleCycles(2);
    rst = 1'b0;

    checkOutput("reset_ready", int'(pix_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_win_valid", int'(win_valid), 0);
    checkOutput("reset_sync", int'({out_sof, out_eol, out_eof}), 0);
    checkOutput("reset_errs", int'({err_sof, err_drop}), 0);

    $display("[TB] back-to-back frame");
    snapshot();
    applyStimulus(N, 0, -1, W + 4);
    checkOutput("t1_win_valid_count", obsWv - baseWv, 20);
    checkOutput("t1_flush_outputs", obsReadyLowWv - baseLow, 6);
    checkOutput("t1_sof_count", obsSof - baseSof, 1);
    checkOutput("t1_eol_count", obsEol - baseEol, 4);
    checkOutput("t1_eof_count", obsEof - baseEof, 1);
    for (int o = 0; o < N; o++)
      checkOutput($sformatf("t2_border_o%0d", o), int'(borderLog[(baseWv + o) % 8192]), int'(borderMap[o]));

    $display("[TB] frame with two-cycle gaps");
    snapshot();
    applyStimulus(N, 2, -1, W + 4);
    checkOutput("t3_win_valid_count", obsWv - baseWv, 20);
    checkOutput("t3_eof_count", obsEof - baseEof, 1);

    $display("[TB] mid-frame sof at i=12");
    snapshot();
    applyStimulus(12 + N, 0, 12, W + 4);
    checkOutput("t4_err_sof", int'(err_sof), 1);
    checkOutput("t4_win_valid_count", obsWv - baseWv, 6 + 20);
    checkOutput("t4_eof_count", obsEof - baseEof, 1);

    $display("[TB] pixels offered during drain");
    snapshot();
    applyStimulus(N, 0, -1, 0);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    idleCycles(3);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    idleCycles(W + 4);
    checkOutput("t5_err_drop", int'(err_drop), 1);
    checkOutput("t5_win_valid_count", obsWv - baseWv, 20);
    checkOutput("t5_eof_count", obsEof - baseEof, 1);
    checkOutput("t5_idle_after", int'(busy), 0);

    $display("[TB] reset during run");
    applyStimulus(10, 0, -1, 0);
    pulseReset();
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_ready", int'(pix_ready), 1);
    checkOutput("t6_win_valid", int'(win_valid), 0);
    checkOutput("t6_errs_cleared", int'({err_sof, err_drop}), 0);
    snapshot();
    applyStimulus(N, -1, -1, W + 4);
    checkOutput("t6_win_valid_count", obsWv - baseWv, 20);
    checkOutput("t6_eof_count", obsEof - baseEof, 1);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      pix_valid = ($urandom_range(0, 9) < 6);
      pix_sof   = pix_valid && ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    idleCycles(N + W + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
